// File: rtl/shift_pkg.sv
// Shared definitions for the shift scheduler: operation codes, FSM states and
// default widths.
package shift_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 5;
   localparam int NREQ_DEF       = 2;

   typedef enum logic [1:0] {
      OP_SLL = 2'd0,
      OP_SRL = 2'd1,
      OP_SRA = 2'd2,
      OP_ROR = 2'd3
   } shift_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/shift_sched_if.sv
// Request/response bundle between the shifter scheduler and its two requesters
// plus the shared result consumer.
interface shift_sched_if
   import shift_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int NREQ       = NREQ_DEF
) ();

   logic [NREQ-1:0]            req_valid;
   logic [NREQ-1:0]            req_ready;
   logic [NREQ*DATA_WIDTH-1:0] req_data;
   logic [NREQ*ADDR_WIDTH-1:0] req_count;
   logic [NREQ*2-1:0]          req_op;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic                       rsp_id;
   logic [DATA_WIDTH-1:0]      rsp_data;
   logic                       busy;

   modport master (
      output req_valid, req_data, req_count, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, busy
   );

   modport slave (
      input  req_valid, req_data, req_count, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, busy
   );

endinterface

// File: rtl/shift_core.sv
// Combinational barrel shifter: logical left/right, arithmetic right and
// rotate right by a count taken modulo DATA_WIDTH.
module shift_core
   import shift_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [ADDR_WIDTH-1:0] count,
   input  shift_op_t             op,
   output logic [DATA_WIDTH-1:0] result
);

   // Left amount for the rotate wraps to 0 when count is 0, so no full-width shift occurs.
   logic [ADDR_WIDTH-1:0] lcount;
   assign lcount = -count;

   always_comb begin
      result = data;
      case (op)
         OP_SLL:  result = data << count;
         OP_SRL:  result = data >> count;
         OP_SRA:  result = $signed(data) >>> count;
         OP_ROR:  result = (data >> count) | (data << lcount);
         default: result = data;
      endcase
   end

endmodule

// File: rtl/shift_sched.sv
// Two-requester scheduler sharing one barrel shifter: round-robin grant in IDLE,
// one EXEC cycle on latched operands, result held in RESP until consumed.
//
// state  | meaning
// S_IDLE | arbitrate requests, req_ready is the one-hot grant
// S_EXEC | shifter evaluates latched operands, result registered
// S_RESP | rsp_valid high, result held until rsp_ready
module shift_sched
   import shift_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int NREQ       = NREQ_DEF
) (
   input  logic          clk,
   input  logic          rst,
   shift_sched_if.slave  bus
);

   state_t                state;
   logic                  rr_ptr;
   logic [NREQ-1:0]       grant;
   logic                  gid;
   logic [DATA_WIDTH-1:0] opd_data;
   logic [ADDR_WIDTH-1:0] opd_count;
   shift_op_t             opd_op;
   logic                  opd_id;
   logic [DATA_WIDTH-1:0] core_res;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  rsp_id_q;
   logic                  rsp_valid_q;

   // Grant is suppressed while reset is asserted so req_ready drops immediately.
   always_comb begin
      grant = '0;
      if (state == S_IDLE && !rst) begin
         case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = '0;
         endcase
      end
   end

   assign gid = grant[1];

   shift_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_core (
      .data   (opd_data),
      .count  (opd_count),
      .op     (opd_op),
      .result (core_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         rr_ptr      <= 1'b0;
         opd_data    <= '0;
         opd_count   <= '0;
         opd_op      <= OP_SLL;
         opd_id      <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|grant) begin
                  opd_data  <= gid ? bus.req_data[DATA_WIDTH +: DATA_WIDTH]
                                   : bus.req_data[0 +: DATA_WIDTH];
                  opd_count <= gid ? bus.req_count[ADDR_WIDTH +: ADDR_WIDTH]
                                   : bus.req_count[0 +: ADDR_WIDTH];
                  opd_op    <= shift_op_t'(gid ? bus.req_op[3:2] : bus.req_op[1:0]);
                  opd_id    <= gid;
                  rr_ptr    <= ~gid;
                  state     <= S_EXEC;
               end
            end
            S_EXEC: begin
               rsp_data_q  <= core_res;
               rsp_id_q    <= opd_id;
               rsp_valid_q <= 1'b1;
               state       <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = grant;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: directed cases plus random traffic, every cycle checked
// against a transaction-level model of arbitration, latency and shift results.
module tb_shift_sched;
   import shift_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   shift_sched_if bus ();

   shift_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   int          outst, age, hs_cnt, acc_cnt, cyc;
   logic        pref, exp_id, last_id, auto_drop;
   logic [31:0] exp_data, last_data;
   int          id_log[$];
   logic [31:0] data_log[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Shift results from plain arithmetic and bit positions.
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int cnt, input int op);
      logic [31:0]     r;
      longint unsigned p;
      int              c;
      c = cnt % 32;
      r = '0;
      case (op)
         0: begin
            p = longint'(d) * (64'd1 << c);
            r = p[31:0];
         end
         1: r = d / (32'd1 << c);
         2: begin
            r = d / (32'd1 << c);
            if (d[31]) for (int i = 0; i < c; i++) r[31-i] = 1'b1;
         end
         default: for (int i = 0; i < 32; i++) r[i] = d[(i + c) % 32];
      endcase
      return r;
   endfunction

   task automatic set_req(input int id, input logic [31:0] d, input logic [4:0] c, input logic [1:0] op);
      bus.req_data[id*32 +: 32] = d;
      bus.req_count[id*5 +: 5]  = c;
      bus.req_op[id*2 +: 2]     = op;
      bus.req_valid[id]         = 1'b1;
   endtask

   // One cycle: called just after a falling edge with inputs driven.
   task automatic step();
      logic [1:0]  er;
      logic [31:0] d;
      logic [4:0]  c;
      logic [1:0]  op;
      logic        hs;
      int          g;
      #1;
      er = 2'b00;
      if (outst == 0) begin
         case (bus.req_valid)
            2'b01:   er = 2'b01;
            2'b10:   er = 2'b10;
            2'b11:   er = pref ? 2'b10 : 2'b01;
            default: er = 2'b00;
         endcase
      end
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      chk("busy", 32'(bus.busy), 32'(outst != 0));
      hs = 1'b0;
      if (outst != 0 && age >= 1) begin
         chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
         chk("rsp_data", bus.rsp_data, exp_data);
         hs = bus.rsp_ready;
         if (hs) begin
            last_id   = bus.rsp_id;
            last_data = bus.rsp_data;
         end
      end else begin
         chk("rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end
      g  = er[1] ? 1 : 0;
      d  = bus.req_data[g*32 +: 32];
      c  = bus.req_count[g*5 +: 5];
      op = bus.req_op[g*2 +: 2];
      @(posedge clk);
      cyc++;
      if (outst != 0) begin
         if (hs) begin
            outst = 0;
            hs_cnt++;
            id_log.push_back(int'(last_id));
            data_log.push_back(last_data);
         end else begin
            age++;
         end
      end else if (er != 2'b00) begin
         outst    = 1;
         age      = 0;
         exp_id   = er[1];
         exp_data = ref_shift(d, int'(c), int'(op));
         pref     = ~er[1];
         acc_cnt++;
      end
      @(negedge clk);
      if (er != 2'b00 && auto_drop) bus.req_valid[g] = 1'b0;
   endtask

   task automatic run_until(input int target, input int budget, input string tag);
      int k;
      k = 0;
      while (hs_cnt < target && k < budget) begin
         step();
         k++;
      end
      if (hs_cnt < target) chk({tag, "_timeout"}, 32'(hs_cnt), 32'(target));
   endtask

   // Reset asserted mid-cycle; outputs must drop without waiting for an edge.
   task automatic do_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      outst = 0;
      age   = 0;
      pref  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_one(input int id, input logic [31:0] d, input logic [4:0] c,
                          input logic [1:0] op, input logic [31:0] exp, input string tag);
      int a0, c0, tgt;
      a0 = acc_cnt;
      c0 = cyc;
      tgt = hs_cnt + 1;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 1'b1;
      set_req(id, d, c, op);
      run_until(tgt, 10, tag);
      chk({tag, "_data"}, last_data, exp);
      chk({tag, "_id"}, 32'(last_id), 32'(id));
      chk({tag, "_accepts"}, 32'(acc_cnt - a0), 32'd1);
      chk({tag, "_cycles"}, 32'(cyc - c0), 32'd3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] snap_d;
      logic        snap_id;
      int          h0, a0, c0;

      rst           = 1'b1;
      bus.req_valid = 2'b00;
      bus.req_data  = '0;
      bus.req_count = '0;
      bus.req_op    = '0;
      bus.rsp_ready = 1'b0;
      outst = 0; age = 0; hs_cnt = 0; acc_cnt = 0; cyc = 0;
      pref = 1'b0; exp_id = 1'b0; last_id = 1'b0; auto_drop = 1'b1;
      exp_data = '0; last_data = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset with both requesters valid while an op is in flight.
      set_req(0, 32'h0000_00F0, 5'd2, OP_SRL);
      set_req(1, 32'h0000_000F, 5'd2, OP_SLL);
      step();
      bus.req_valid = 2'b11;
      do_reset("rst_mid");
      #1;
      chk("rst_first_grant", 32'(bus.req_ready), 32'd1);
      bus.rsp_ready = 1'b1;
      bus.req_valid = 2'b01;
      run_until(hs_cnt + 1, 10, "rst_first_op");
      chk("rst_first_id", 32'(last_id), 32'd0);

      run_one(0, 32'h8000_0001, 5'd4, OP_SLL, 32'h0000_0010, "sll");
      run_one(0, 32'h8000_0001, 5'd4, OP_SRL, 32'h0800_0000, "srl");
      run_one(0, 32'h8000_0001, 5'd4, OP_SRA, 32'hF800_0000, "sra");
      run_one(0, 32'h8000_0001, 5'd4, OP_ROR, 32'h1800_0000, "ror");
      run_one(0, 32'h1234_5678, 5'd0, OP_ROR, 32'h1234_5678, "ror_c0");
      run_one(1, 32'h1234_5678, 5'd31, OP_ROR, 32'h2468_ACF0, "ror_c31");
      run_one(0, 32'h7FFF_FFFF, 5'd31, OP_SRA, 32'h0000_0000, "sra_c31");

      // Contention from a freshly reset pointer.
      bus.req_valid = 2'b00;
      do_reset("rst_idle");
      auto_drop = 1'b0;
      id_log.delete();
      data_log.delete();
      set_req(0, 32'd1, 5'd1, OP_SLL);
      set_req(1, 32'd2, 5'd1, OP_SRL);
      bus.rsp_ready = 1'b1;
      c0 = cyc;
      run_until(hs_cnt + 4, 30, "cont");
      bus.req_valid = 2'b00;
      auto_drop = 1'b1;
      chk("cont_n", 32'(id_log.size()), 32'd4);
      chk("cont_cycles", 32'(cyc - c0), 32'd12);
      for (int i = 0; i < id_log.size() && i < 4; i++) begin
         chk("cont_id", 32'(id_log[i]), 32'(i % 2));
         chk("cont_data", data_log[i], (i % 2 == 0) ? 32'd2 : 32'd1);
      end

      // Backpressure with a second request waiting.
      bus.rsp_ready = 1'b0;
      set_req(0, 32'hA5A5_0F0F, 5'd3, OP_ROR);
      step();
      step();
      set_req(1, 32'h0000_00FF, 5'd2, OP_SLL);
      snap_d  = bus.rsp_data;
      snap_id = bus.rsp_id;
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      repeat (5) begin
         step();
         chk("bp_stable_data", bus.rsp_data, snap_d);
         chk("bp_stable_id", 32'(bus.rsp_id), 32'(snap_id));
      end
      bus.rsp_ready = 1'b1;
      h0 = hs_cnt;
      a0 = acc_cnt;
      step();
      chk("bp_one_hs", 32'(hs_cnt - h0), 32'd1);
      chk("bp_no_bypass", 32'(acc_cnt - a0), 32'd0);
      step();
      chk("bp_next_accept", 32'(acc_cnt - a0), 32'd1);
      run_until(h0 + 2, 10, "bp_drain");
      chk("bp_second_id", 32'(last_id), 32'd1);

      // Reset during EXEC of a requester-1 op: the result is discarded.
      h0 = hs_cnt;
      set_req(1, 32'h0000_1234, 5'd1, OP_SLL);
      step();
      do_reset("rst_exec1");
      repeat (4) step();
      chk("rst_exec1_no_rsp", 32'(hs_cnt - h0), 32'd0);

      // Reset during EXEC of a requester-0 op must still leave the pointer at 0.
      set_req(0, 32'h0000_4321, 5'd1, OP_SRL);
      step();
      do_reset("rst_exec0");
      set_req(0, 32'h0000_0003, 5'd1, OP_SLL);
      set_req(1, 32'h0000_0003, 5'd1, OP_SRL);
      #1;
      chk("rst_exec0_ptr", 32'(bus.req_ready), 32'd1);
      h0 = hs_cnt;
      run_until(h0 + 2, 20, "rst_exec0_ops");
      if (id_log.size() >= 2) begin
         chk("rst_exec0_ord0", 32'(id_log[id_log.size()-2]), 32'd0);
         chk("rst_exec0_ord1", 32'(id_log[id_log.size()-1]), 32'd1);
      end

      // Random traffic.
      repeat (400) begin
         for (int i = 0; i < 2; i++) begin
            if (!bus.req_valid[i] && $urandom_range(0, 1) == 1)
               set_req(i, $urandom, 5'($urandom), 2'($urandom));
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      bus.rsp_ready = 1'b1;
      repeat (12) step();
      bus.req_valid = 2'b00;
      repeat (4) step();
      chk("final_idle", 32'(bus.busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
